// File: rtl/tdl_pkg.sv
// Shared sizing helpers for the multichannel tapped delay line and the filter blocks fed by it.
// Tap vectors are logic [DEPTH-1:0][WIDTH-1:0]: element 0 newest, element DEPTH-1 oldest.
`ifndef TDL_TAPS_T
`define TDL_TAPS_T(W, D) logic [(D)-1:0][(W)-1:0]
`endif

package tdl_pkg;

  // Channel index width; never narrower than one bit so a single-channel build still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Fill counter width able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tdl_multichannel_if.sv
// Sample-in / tap-vector-out stream bundle of the tapped delay line.
interface tdl_multichannel_if #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
);
  import tdl_pkg::*;
  localparam int IW = idx_w(CHANNELS);

  // Both channels use valid/ready: a beat transfers on a rising edge where valid && ready;
  // the producer holds valid and payload stable until that edge, and ready may depend on valid.
  logic                         in_valid;
  logic                         in_ready;
  logic [IW-1:0]                in_ch;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [IW-1:0]                out_ch;
  logic [DEPTH-1:0][WIDTH-1:0]  out_taps;
  logic                         out_full;

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_taps, out_full
  );

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_taps, out_full
  );
endinterface

// File: rtl/tdl_channel_line.sv
// One channel's delay line: DEPTH-tap shift register plus a fill counter saturating at DEPTH.
module tdl_channel_line import tdl_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_shift,
  input  logic                        i_clear,
  input  logic [WIDTH-1:0]            i_din,
  output logic [DEPTH-1:0][WIDTH-1:0] o_taps,
  output logic                        o_full,
  output logic                        o_last
);
  localparam int             CW       = cnt_w(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] r_taps;
  logic [CW-1:0]               r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_taps <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_taps <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_taps <= {r_taps[DEPTH-2:0], i_din};
      if (r_cnt != FULL_CNT) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_taps = r_taps;
  assign o_full = (r_cnt == FULL_CNT);
  // One more sample fills the line; lets the top report full on the accepting edge.
  assign o_last = (r_cnt == LAST_CNT);
endmodule

// File: rtl/tdl_multichannel.sv
// Multichannel tapped delay line: channel decode, valid/ready handshake and the output register.
module tdl_multichannel import tdl_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  tdl_multichannel_if.slave    io,
  output logic                 err_ch
);
  localparam int IW = idx_w(CHANNELS);
  typedef `TDL_TAPS_T(WIDTH, DEPTH) taps_t;

  taps_t               w_line_taps [CHANNELS];
  logic [CHANNELS-1:0] w_line_full;
  logic [CHANNELS-1:0] w_line_last;
  logic [CHANNELS-1:0] w_shift;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_legal;
  taps_t               w_sel_taps;
  logic                w_sel_full;

  logic                r_out_valid;
  logic [IW-1:0]       r_out_ch;
  taps_t               r_out_taps;
  logic                r_out_full;
  logic                r_err;

  assign w_in_ready = !flush && (!r_out_valid || io.out_ready);
  assign w_accept   = io.in_valid && w_in_ready;
  assign w_legal    = (int'(io.in_ch) < CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_line
    assign w_shift[c] = w_accept && (int'(io.in_ch) == c);

    tdl_channel_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_line (
      .clk     (clk),
      .rstn    (rstn),
      .i_shift (w_shift[c]),
      .i_clear (flush),
      .i_din   (io.in_data),
      .o_taps  (w_line_taps[c]),
      .o_full  (w_line_full[c]),
      .o_last  (w_line_last[c])
    );
  end

  // Post-shift view of the addressed line, built from line state so same-channel bursts chain.
  always_comb begin
    w_sel_taps = '0;
    w_sel_full = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(io.in_ch) == c) begin
        w_sel_taps = {w_line_taps[c][DEPTH-2:0], io.in_data};
        w_sel_full = w_line_full[c] || w_line_last[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_taps  <= '0;
      r_out_full  <= 1'b0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_taps  <= '0;
      r_out_full  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= io.in_ch;
        r_out_taps  <= w_sel_taps;
        r_out_full  <= w_sel_full;
      end else if (io.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_ch    = r_out_ch;
  assign io.out_taps  = r_out_taps;
  assign io.out_full  = r_out_full;
  assign err_ch       = r_err;
endmodule

// File: tb/tb_tdl_multichannel.sv
// Bench for tdl_multichannel: 2-channel DEPTH=4 instance on a scoreboard, 3-channel instance for illegal indices.
module tb_tdl_multichannel;
  localparam int EXP_W = 66;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic flush3;
  logic err0;
  logic err3;

  tdl_multichannel_if #(.WIDTH(16), .DEPTH(4), .CHANNELS(2)) io  ();
  tdl_multichannel_if #(.WIDTH(16), .DEPTH(4), .CHANNELS(3)) io3 ();

  tdl_multichannel #(.WIDTH(16), .DEPTH(4), .CHANNELS(2)) u_dut (
    .clk (clk), .rstn (rstn), .flush (flush), .io (io.slave), .err_ch (err0)
  );

  tdl_multichannel #(.WIDTH(16), .DEPTH(4), .CHANNELS(3)) u_dut3 (
    .clk (clk), .rstn (rstn), .flush (flush3), .io (io3.slave), .err_ch (err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] din;
    logic [63:0] taps;
    logic        full;
  } vec_t;

  vec_t vecs [8];
  logic [EXP_W-1:0] exp_q [$];
  logic [EXP_W-1:0] got;
  int n_checks = 0;
  int n_pass = 0;
  int valid_cycles = 0;
  int v0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] taps4(input logic [15:0] t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ch, input logic [15:0] d, input logic [63:0] taps, input logic full);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_ch    = 1'(ch);
    io.in_data  = d;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) begin
      check("send_timeout", 128'(0), 128'(1));
    end else begin
      exp_q.push_back({1'(ch), full, taps});
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    check("latency_out_valid", 128'(io.out_valid), 128'(1));
  endtask

  task automatic drive3(input int ch, input logic [15:0] d);
    io3.in_valid = 1'b1;
    io3.in_ch    = 2'(ch);
    io3.in_data  = d;
    @(posedge clk);
    #1;
    io3.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (io.out_valid) valid_cycles++;
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 128'(1), 128'(0));
        end else begin
          got = exp_q.pop_front();
          check("sb_vector", 128'({io.out_ch, io.out_full, io.out_taps}), 128'(got));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 16'd1,  taps4(16'd1,  16'd0,  16'd0, 16'd0), 1'b0};
    vecs[1] = '{0, 16'd2,  taps4(16'd2,  16'd1,  16'd0, 16'd0), 1'b0};
    vecs[2] = '{0, 16'd3,  taps4(16'd3,  16'd2,  16'd1, 16'd0), 1'b0};
    vecs[3] = '{0, 16'd4,  taps4(16'd4,  16'd3,  16'd2, 16'd1), 1'b1};
    vecs[4] = '{0, 16'd5,  taps4(16'd5,  16'd4,  16'd3, 16'd2), 1'b1};
    vecs[5] = '{0, 16'd10, taps4(16'd10, 16'd0,  16'd0, 16'd0), 1'b0};
    vecs[6] = '{1, 16'd20, taps4(16'd20, 16'd0,  16'd0, 16'd0), 1'b0};
    vecs[7] = '{0, 16'd11, taps4(16'd11, 16'd10, 16'd0, 16'd0), 1'b0};

    // Clock/reset
    rstn = 1'b0;
    flush = 1'b0;
    flush3 = 1'b0;
    io.in_valid = 1'b0; io.in_ch = '0; io.in_data = '0; io.out_ready = 1'b1;
    io3.in_valid = 1'b0; io3.in_ch = '0; io3.in_data = '0; io3.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 128'(io.out_valid), 128'(0));
    check("rst_out_taps",  128'(io.out_taps),  128'(0));
    check("rst_out_ch",    128'(io.out_ch),    128'(0));
    check("rst_out_full",  128'(io.out_full),  128'(0));
    check("rst_err_ch",    128'(err0),         128'(0));
    check("rst_in_ready",  128'(io.in_ready),  128'(1));
    @(posedge clk);
    #1;

    // Fill ch0 back-to-back
    v0 = valid_cycles;
    for (int i = 0; i < 5; i++) send(vecs[i].ch, vecs[i].din, vecs[i].taps, vecs[i].full);
    @(negedge clk);
    #1;
    check("fill_valid_cycles", 128'(valid_cycles - v0), 128'(5));
    @(posedge clk);
    #1;
    check("fill_valid_drop", 128'(io.out_valid), 128'(0));

    // Reset mid-stream while a vector is pending
    send(1, 16'd99, taps4(16'd99, 16'd0, 16'd0, 16'd0), 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 128'(io.out_valid), 128'(0));
    check("midrst_out_taps",  128'(io.out_taps),  128'(0));
    check("midrst_out_ch",    128'(io.out_ch),    128'(0));
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send(0, 16'd5, taps4(16'd5, 16'd0, 16'd0, 16'd0), 1'b0);

    // Flush, then interleave channels
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 5; i < 8; i++) send(vecs[i].ch, vecs[i].din, vecs[i].taps, vecs[i].full);
    @(posedge clk);
    #1;

    // Backpressure
    io.out_ready = 1'b0;
    send(1, 16'd30, taps4(16'd30, 16'd20, 16'd0, 16'd0), 1'b0);
    io.in_valid = 1'b1;
    io.in_ch    = 1'b1;
    io.in_data  = 16'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  128'(io.in_ready),  128'(0));
      check("bp_out_valid", 128'(io.out_valid), 128'(1));
      check("bp_out_taps",  128'(io.out_taps),  128'(taps4(16'd30, 16'd20, 16'd0, 16'd0)));
      check("bp_out_ch",    128'(io.out_ch),    128'(1));
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    send(1, 16'd31, taps4(16'd31, 16'd30, 16'd20, 16'd0), 1'b0);

    // Flush with a simultaneous sample
    flush = 1'b1;
    io.in_valid = 1'b1;
    io.in_ch    = 1'b0;
    io.in_data  = 16'd9;
    @(negedge clk);
    check("flush_in_ready", 128'(io.in_ready), 128'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 128'(io.out_valid), 128'(0));
    @(posedge clk);
    #1;
    send(0, 16'd7, taps4(16'd7, 16'd0, 16'd0, 16'd0), 1'b0);
    send(1, 16'd8, taps4(16'd8, 16'd0, 16'd0, 16'd0), 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("sb_drain", 128'(exp_q.size()), 128'(0));
    check("err_main_quiet", 128'(err0), 128'(0));

    // Illegal channel on the 3-channel instance
    @(posedge clk);
    #1;
    drive3(2, 16'd40);
    @(negedge clk);
    check("ch3_out_valid", 128'(io3.out_valid), 128'(1));
    check("ch3_out_ch",    128'(io3.out_ch),    128'(2));
    check("ch3_out_taps",  128'(io3.out_taps),  128'(taps4(16'd40, 16'd0, 16'd0, 16'd0)));
    @(posedge clk);
    #1;
    drive3(3, 16'd41);
    @(negedge clk);
    check("illegal_err_pulse", 128'(err3),           128'(1));
    check("illegal_out_valid", 128'(io3.out_valid),  128'(0));
    @(negedge clk);
    check("illegal_err_clear", 128'(err3),           128'(0));
    check("illegal_out_idle",  128'(io3.out_valid),  128'(0));
    @(posedge clk);
    #1;
    drive3(2, 16'd42);
    @(negedge clk);
    check("after_illegal_taps", 128'(io3.out_taps), 128'(taps4(16'd42, 16'd40, 16'd0, 16'd0)));
    check("after_illegal_full", 128'(io3.out_full), 128'(0));
    check("after_illegal_ch",   128'(io3.out_ch),   128'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tdl_multichannel.md
# tdl_multichannel

Multichannel tapped delay line for the adaptive filter datapath. It holds an independent DEPTH-tap history per channel, fed by a single time-multiplexed sample stream. For each accepted sample it presents that channel's updated tap vector and a fill-status flag, with valid/ready flow control, to the downstream FIR/LMS stage. A synchronous flush returns all histories to zero without a reset.

## Interface
- WIDTH, 16: sample width in bits, two's-complement, passed through unmodified.
- DEPTH, 8: taps per channel, ≥2.
- CHANNELS, 2: number of independent delay lines, ≥1.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all lines, fill counts and output register.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept; equals !out_valid || out_ready, forced 0 while flush=1.
- in_ch  in  $clog2(CHANNELS) (min 1)  channel index of the input sample.
- in_data  in  WIDTH  input sample.
- out_valid  out  1  tap vector valid.
- out_ready  in  1  downstream accepts tap vector.
- out_ch  out  $clog2(CHANNELS) (min 1)  channel the tap vector belongs to.
- out_taps  out  DEPTH×WIDTH  packed; out_taps[0] = newest, out_taps[DEPTH-1] = oldest.
- out_full  out  1  channel has received ≥DEPTH samples since the last reset or flush.
- err_ch  out  1  one-cycle pulse: a sample with in_ch ≥ CHANNELS was accepted.

## Operation
- Accept = in_valid && in_ready.
- On accept with a legal in_ch = c:
  - Line c shifts one place: tap[k] ← tap[k-1] for k = DEPTH-1 down to 1, and tap[0] ← in_data.
  - The old tap[DEPTH-1] is discarded.
  - Other channels are unchanged.
- Fill count per channel: width $clog2(DEPTH+1), increments on each accept for that channel, saturates at DEPTH. out_full = (post-increment count == DEPTH).
- The output register loads the post-shift taps of c, out_ch=c and out_full, and sets out_valid.
- Illegal in_ch: the sample is consumed. No line, count or output register changes. err_ch pulses.
- Output handshake:
  - out_valid clears on out_ready unless a new accept loads it in the same cycle.
  - While out_valid && !out_ready, the output register and all lines hold.
- Flush, which has priority over everything:
  - All lines and counts go to 0, out_valid goes to 0, and in_ready is 0 that cycle.
  - Any simultaneous in_valid sample is dropped, not accepted.
- Reset values: all lines and counts 0; out_valid 0, out_taps 0, out_ch 0, out_full 0, err_ch 0. in_ready is 1 once rstn deasserts. Reset asserted mid-stream clears everything immediately.

## Timing
- Latency is 1 cycle: a sample accepted at edge N gives out_valid=1 with its taps after edge N.
- Throughput is 1 sample/cycle while out_ready=1. Back-to-back samples to the same channel chain correctly because each shift uses the line state, not the output register.
- in_ready is combinational from out_valid, out_ready and flush. There is no combinational path from in_* to out_*.
- err_ch is high for exactly the cycle after an illegal accept.
- Simultaneous out_ready and accept: the old vector is consumed and the new vector is loaded on the same edge, so out_valid stays 1.

## Structure
- Package tdl_pkg holds:
  - the function computing index width (max(1, $clog2(N)));
  - the count-width helper;
  - the packed tap-vector typedef macro/parameterised type convention used by downstream filter blocks.
- Sub-module tdl_channel_line contains one channel's shift register plus its saturating fill counter.
  - Inputs: shift enable, clear, din.
  - Outputs: taps, full.
  - Instantiated CHANNELS times via generate.
- The top level holds the channel decode, the handshake logic and the output register.

## Test plan
All scenarios use WIDTH=16, DEPTH=4, CHANNELS=2.
- Reset: after rstn deasserts, all outputs are 0 and in_ready=1. Assert rstn mid-stream, then release: the next ch0 sample 5 gives taps {5,0,0,0}, full=0.
- Fill ch0 with 1,2,3,4,5 back-to-back, out_ready=1:
  - out_valid is high for 5 consecutive cycles, each one cycle after its accept.
  - Final taps {5,4,3,2}.
  - out_full sequence 0,0,0,1,1.
- Interleave ch0=10, ch1=20, ch0=11: outputs ch0 {10,0,0,0}, ch1 {20,0,0,0}, ch0 {11,10,0,0}. Channels stay independent.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - in_ready=0 and out_taps/out_ch are stable throughout.
  - On release, the pending sample is accepted on that edge and appears next cycle.
- Flush with in_valid=1, ch0=9 in the same cycle:
  - The sample is dropped and out_valid=0.
  - The next ch0=7 gives {7,0,0,0}, full=0, and ch1 is also cleared.
- Illegal channel: in_ch=3 (CHANNELS=2, index width 1, so drive in_ch=1 with CHANNELS=1 build; in the 2-channel build use a CHANNELS=3 variant with in_ch=3).
  - err_ch pulses once and out_valid stays 0.
  - The next legal sample shows the line unchanged.
